// File: rtl/up_counter_pkg.sv
// Shared definitions for the up counter run controller and its datapath.
package up_counter_pkg;

    localparam int UP_COUNTER_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/up_counter_core.sv
// Counter datapath: loadable N-bit up counter with modulo-2^N wrap.
module up_counter_core #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] Q
);

    // Count register; a load wins over an increment in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q <= '0;
        end else if (load) begin
            Q <= load_val;
        end else if (en) begin
            Q <= Q + {{(N-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/up_counter_ctrl.sv
// Run controller for the up counter: loads a start value, counts to an end
// value (wrapping modulo 2^N), then stops or reloads. Supports pause/abort.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | waiting for start; Q holds its last value
//   ST_LOAD | single cycle that copies the captured start value into Q
//   ST_RUN  | counting; terminal count pulses done, then reload or stop
module up_counter_ctrl
    import up_counter_pkg::*;
#(
    parameter int N = UP_COUNTER_WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    input  logic         pause,
    input  logic         auto_reload,
    input  logic [N-1:0] start_val,
    input  logic [N-1:0] end_val,
    output logic [N-1:0] Q,
    output logic         busy,
    output logic         done
);

    state_t       state;
    logic [N-1:0] start_r;
    logic [N-1:0] end_r;
    logic         reload_r;
    logic         core_load;
    logic         core_en;
    logic         at_end;

    assign at_end = (Q == end_r);

    // Datapath controls derived from the current state; terminal count beats pause.
    always_comb begin
        core_load = 1'b0;
        core_en   = 1'b0;
        case (state)
            ST_LOAD: begin
                core_load = !abort;
            end
            ST_RUN: begin
                if (!abort) begin
                    if (at_end) begin
                        core_load = reload_r;
                    end else begin
                        core_en = !pause;
                    end
                end
            end
            default: begin
                core_load = 1'b0;
                core_en   = 1'b0;
            end
        endcase
    end

    up_counter_core #(.N(N)) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (core_en),
        .load     (core_load),
        .load_val (start_r),
        .Q        (Q)
    );

    // Run sequencing, config capture and the registered busy/done outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            start_r  <= '0;
            end_r    <= '0;
            reload_r <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        start_r  <= start_val;
                        end_r    <= end_val;
                        reload_r <= auto_reload;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (at_end) begin
                        done <= 1'b1;
                        if (!reload_r) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    // Unused encoding: recover to a quiet idle.
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Self-checking bench for up_counter_ctrl: directed scenarios with literal
// expectations plus randomized stimulus against a run-position model.
module tb_up_counter_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       pause;
    logic       auto_reload;
    logic [7:0] start_val;
    logic [7:0] end_val;
    logic [7:0] Q;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    up_counter_ctrl #(.N(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .pause       (pause),
        .auto_reload (auto_reload),
        .start_val   (start_val),
        .end_val     (end_val),
        .Q           (Q),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a run is "position pos of L values starting at sv".
    logic       m_busy, m_loading, m_done, m_rel;
    logic [7:0] m_q, m_sv, m_ev;
    int         m_pos, m_len;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_loading = 0; m_done = 0; m_rel = 0;
            m_q = 0; m_sv = 0; m_ev = 0; m_pos = 0; m_len = 1;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    m_sv = start_val; m_ev = end_val; m_rel = auto_reload;
                    m_len = int'(8'(end_val - start_val)) + 1;
                    m_busy = 1; m_loading = 1;
                end
            end else if (m_loading) begin
                m_loading = 0;
                if (abort) m_busy = 0;
                else begin m_pos = 0; m_q = m_sv; end
            end else if (abort) begin
                m_busy = 0;
            end else if (m_pos == m_len - 1) begin
                m_done = 1;
                if (m_rel) begin m_pos = 0; m_q = m_sv; end
                else m_busy = 0;
            end else if (!pause) begin
                m_pos = m_pos + 1;
                m_q = 8'(int'(m_sv) + m_pos);
            end
        end
    end

    // Every cycle, outputs must match the model.
    always @(negedge clk) begin
        n_checks++;
        if (Q !== m_q || busy !== m_busy || done !== m_done) begin
            n_errors++;
            $display("FAIL model_cmp t=%0t: Q=%0d busy=%0b done=%0b, expected Q=%0d busy=%0b done=%0b",
                     $time, Q, busy, done, m_q, m_busy, m_done);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic go(input logic [7:0] sv, input logic [7:0] ev, input logic rel);
        start = 1; start_val = sv; end_val = ev; auto_reload = rel;
        tick();
        start = 0;
        chk("start_busy", busy, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        reset_n = 1; start = 0; abort = 0; pause = 0; auto_reload = 0;
        start_val = 0; end_val = 0;
        #1 reset_n = 0;
        tick(); tick();
        chk("reset_q", Q, 0); chk("reset_busy", busy, 0); chk("reset_done", done, 0);
        reset_n = 1;
        tick();

        // One-shot 3..7
        go(8'd3, 8'd7, 1'b0);
        busy_cnt = 1;
        for (int v = 3; v <= 7; v++) begin
            tick();
            chk("oneshot_q", Q, v); chk("oneshot_done_low", done, 0);
            busy_cnt += busy;
        end
        tick();
        chk("oneshot_done", done, 1); chk("oneshot_busy_off", busy, 0); chk("oneshot_hold", Q, 7);
        chk("oneshot_busy_len", busy_cnt, 6);
        tick();
        chk("oneshot_done_fall", done, 0); chk("oneshot_hold2", Q, 7);

        // Wrap 254..1
        go(8'd254, 8'd1, 1'b0);
        tick(); chk("wrap_q0", Q, 254);
        tick(); chk("wrap_q1", Q, 255);
        tick(); chk("wrap_q2", Q, 0);
        tick(); chk("wrap_q3", Q, 1); chk("wrap_nodone", done, 0);
        tick(); chk("wrap_done", done, 1); chk("wrap_q_hold", Q, 1);

        // Auto-reload 2..4, then abort at Q=3
        go(8'd2, 8'd4, 1'b1);
        tick(); chk("rl_q2", Q, 2);
        tick(); chk("rl_q3", Q, 3);
        tick(); chk("rl_q4", Q, 4); chk("rl_nodone", done, 0);
        tick(); chk("rl_q2b", Q, 2); chk("rl_done1", done, 1); chk("rl_busy", busy, 1);
        tick(); chk("rl_q3b", Q, 3); chk("rl_done_fall", done, 0);
        abort = 1;
        tick(); chk("abort_q", Q, 3); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
        abort = 0;
        tick(); chk("abort_hold", Q, 3); chk("abort_done2", done, 0);

        // Pause run 0..9, with an ignored start mid-run
        go(8'd0, 8'd9, 1'b0);
        for (int v = 0; v <= 5; v++) begin
            tick();
            chk("pause_q", Q, v);
            if (v == 2) begin start = 1; start_val = 8'd0; end_val = 8'd200; end
            else start = 0;
        end
        pause = 1;
        for (int i = 0; i < 3; i++) begin tick(); chk("pause_hold", Q, 5); end
        pause = 0;
        for (int v = 6; v <= 9; v++) begin tick(); chk("pause_resume", Q, v); end
        pause = 1;
        tick(); chk("pause_term_done", done, 1); chk("pause_term_q", Q, 9); chk("pause_term_busy", busy, 0);
        pause = 0;

        // Degenerate L=1
        go(8'd9, 8'd9, 1'b0);
        tick(); chk("l1_q", Q, 9); chk("l1_nodone", done, 0);
        tick(); chk("l1_done", done, 1); chk("l1_busy", busy, 0);

        // Async reset at Q=6
        go(8'd0, 8'd20, 1'b0);
        for (int v = 0; v <= 6; v++) tick();
        chk("pre_rst_q", Q, 6);
        #2 reset_n = 0;
        #1;
        chk("arst_q", Q, 0); chk("arst_busy", busy, 0); chk("arst_done", done, 0);
        #1 reset_n = 1;
        tick();
        go(8'd10, 8'd11, 1'b0);
        tick(); chk("post_rst_q10", Q, 10);
        tick(); chk("post_rst_q11", Q, 11);
        tick(); chk("post_rst_done", done, 1);

        // Randomized phase, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            tick();
            start       = ($urandom % 4) == 0;
            abort       = ($urandom % 40) == 0;
            pause       = ($urandom % 5) == 0;
            auto_reload = ($urandom % 3) == 0;
            start_val   = 8'($urandom);
            end_val     = (($urandom % 4) != 0) ? 8'(start_val + 8'($urandom % 12)) : 8'($urandom);
            if (($urandom % 700) == 0) begin
                #1 reset_n = 0;
                #1 reset_n = 1;
            end
        end
        start = 0; abort = 0; pause = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/up_counter_ctrl.md
# up_counter_ctrl

Run controller for the N-bit up counter. It loads a programmable start value, counts up to a programmable end value with modulo-2^N wrap, and then stops or auto-reloads. It supports pause and abort, and emits a one-cycle `done` pulse per completed run. It sits between the system-level control logic and the counter datapath, which it instantiates.

## Interface
- `N`, default 8: counter, start and end width in bits.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: level sampled each edge; acted on only in IDLE.
- `abort` in 1: level sampled each edge; acted on only in LOAD/RUN.
- `pause` in 1: level; while high in RUN, the count holds.
- `auto_reload` in 1: captured on an accepted `start`.
- `start_val` in N: first count value; captured on an accepted `start`.
- `end_val` in N: terminal count value; captured on an accepted `start`.
- `Q` out N: current count.
- `busy` out 1: high in LOAD and RUN.
- `done` out 1: one-cycle pulse on terminal count.

## Operation
- The FSM has three states: IDLE, LOAD and RUN.
- Registers: `start_r`, `end_r`, `reload_r` (captured config), `Q`, `busy`, `done`. All outputs are registered.
- **IDLE**
  - `Q` holds its last value.
  - `start`=1 → capture config, go to LOAD, `busy`<=1.
  - `abort` and `pause` are ignored.
- **LOAD** (exactly one cycle)
  - `Q`<=`start_r`, go to RUN.
  - `abort`=1 → go to IDLE with `Q` unchanged and `busy`<=0.
- **RUN**, evaluated each edge in priority order:
  1. `abort`=1 → go to IDLE, `Q` holds, `busy`<=0, no `done`.
  2. `Q`==`end_r` → `done`<=1. If `reload_r`, then `Q`<=`start_r` and stay in RUN. Otherwise go to IDLE, `Q` holds `end_r`, `busy`<=0.
  3. `pause`=1 → `Q` holds.
  4. Otherwise `Q`<=`Q`+1 mod 2^N.
- A terminal count takes priority over `pause`.
- `start`, `start_val`, `end_val` and `auto_reload` are ignored while busy. Config is changed only via abort then restart.
- Run length L = ((`end_val` − `start_val`) mod 2^N) + 1 counted values, excluding paused cycles.
  - `start_val`==`end_val` gives L=1.
  - Wrap through 2^N−1 → 0 is legal and silent.
- `done` is otherwise 0 and is never high for two consecutive cycles, except in auto-reload with L=1, where it is high every RUN cycle.

## Timing
- Reset (async, immediate, no clock edge needed): state IDLE, `Q`=0, `busy`=0, `done`=0, `start_r`=0, `end_r`=0, `reload_r`=0.
- Release of `reset_n` is synchronised externally; the first edge after release is a normal IDLE edge.
- `start` accepted at edge k:
  - `busy`=1 from k.
  - `Q`=`start_val` from k+1.
  - `Q`=`start_val`+1 from k+2 (no pause).
- Terminal: `Q`==`end_r` is visible after edge e. At e+1, `done`=1, and `busy`=0 if not reloading. `done` falls at e+2.
- Without pause, one-shot `busy` high time is L+1 cycles.
- Reset asserted mid-run aborts immediately; no `done` is produced.

## Structure
- Package `up_counter_pkg`:
  - 2-bit state encodings: `ST_IDLE`=0, `ST_LOAD`=1, `ST_RUN`=2. Encoding 3 is illegal → next state IDLE.
  - Default width constant 8.
- Sub-module `up_counter_core`:
  - Ports: `clk`, `reset_n`, `en`, `load`, `load_val[N-1:0]`, `Q[N-1:0]`.
  - Behaviour: async reset to 0; `load` has priority over `en`.
  - The controller drives `load` in LOAD and on reload, and `en` in RUN when neither abort, terminal nor pause applies.
- The FSM, config registers, `busy` and `done` live in `up_counter_ctrl`.

## Test plan
All scenarios use N=8.
- **One-shot:** reset, `start` with `start_val`=3, `end_val`=7, `auto_reload`=0 → `Q`=3,4,5,6,7; `done` one cycle after `Q`=7; `busy` high 6 cycles; `Q` holds 7.
- **Wrap:** `start_val`=254, `end_val`=1 → `Q`=254,255,0,1 then `done`; L=4.
- **Auto-reload and abort:**
  - `start_val`=2, `end_val`=4, `auto_reload`=1 → `Q`=2,3,4,2,3,4,… with a `done` pulse in each cycle `Q` returns to 2.
  - `abort` at `Q`=3 → IDLE, `Q`=3, no `done`.
- **Pause:**
  - Run 0→9; `pause` high 3 cycles at `Q`=5 → `Q`=5 for 4 cycles total, then 6.
  - `pause` held at `Q`=9 → `done` still fires.
- **Degenerate/ignored input:**
  - `start_val`=`end_val`=9 → `Q`=9 for one cycle, then `done`.
  - `start` with `start_val`=0 during RUN → ignored, run unaffected.
- **Async reset:** assert `reset_n`=0 mid-cycle at `Q`=6 → `Q`=0, `busy`=0, `done`=0 before the next edge; the next `start` operates normally.
